// File: rtl/dca_lpi_outstanding_tracker_pkg.sv
// dca_lpi_outstanding_tracker_pkg: shared width helpers for the LPI outstanding tracker and LSU front-ends
package dca_lpi_outstanding_tracker_pkg;
  function automatic int chid_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/dca_lpi_tag_fifo.sv
// dca_lpi_tag_fifo: in-order channel-id FIFO with push/pop, flush, full/empty, count and head
module dca_lpi_tag_fifo
  import dca_lpi_outstanding_tracker_pkg::*;
#(
  parameter int W = 1,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign head = mem_q[rd_q];
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  always_comb begin
    mem_d = mem_q;
    mem_d[wr_q] = do_push ? din : mem_q[wr_q];
    wr_d = flush ? '0 : wr_q + PW'(do_push);
    rd_d = flush ? '0 : rd_q + PW'(do_pop);
    count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/dca_lpi_outstanding_tracker.sv
// dca_lpi_outstanding_tracker: round-robin LPI request arbiter with in-order response routing by channel tag
module dca_lpi_outstanding_tracker
  import dca_lpi_outstanding_tracker_pkg::*;
#(
  parameter int NUM_CHANNEL = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BW_LPI_YDATA = 32,
  parameter int BW_LPI_BURDEN = 1,
  localparam int BW_CHID = chid_w(NUM_CHANNEL),
  localparam int BW_CNT = cnt_w(MAX_OUTSTANDING)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [NUM_CHANNEL-1:0]  ch_sreq_valid,
  output logic [NUM_CHANNEL-1:0]  ch_sreq_ready,
  output logic                    sreq_valid,
  input  logic                    sreq_ready,
  output logic [BW_CHID-1:0]      sreq_chid,
  input  logic                    yvalid,
  output logic                    yready,
  input  logic [BW_LPI_YDATA-1:0] ydata,
  output logic [NUM_CHANNEL-1:0]  ch_yvalid,
  input  logic [NUM_CHANNEL-1:0]  ch_yready,
  output logic [BW_LPI_YDATA-1:0] ch_ydata,
  output logic                    busy,
  output logic [BW_CNT-1:0]       outstanding,
  output logic                    err_unexpected
);
  logic live, full, empty, hs, pop, burden, any_hi;
  logic gnt_valid_q, gnt_valid_d, err_q, err_d;
  logic [BW_CHID-1:0] gnt_q, gnt_d, rr_q, rr_d, pick_hi, pick_lo, head;
  logic [BW_CNT-1:0] count;
  assign live = !rst & !clear;
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    any_hi = 1'b0;
    for (int j = NUM_CHANNEL - 1; j >= 0; j--) begin
      pick_lo = ch_sreq_valid[j] ? BW_CHID'(j) : pick_lo;
      pick_hi = ch_sreq_valid[j] && BW_CHID'(j) >= rr_q ? BW_CHID'(j) : pick_hi;
      any_hi = any_hi | (ch_sreq_valid[j] && BW_CHID'(j) >= rr_q);
    end
  end
  assign sreq_valid = live & (gnt_valid_q | (enable & !full & |ch_sreq_valid));
  assign sreq_chid = !live ? '0 : gnt_valid_q ? gnt_q : any_hi ? pick_hi : pick_lo;
  assign hs = sreq_valid & sreq_ready;
  assign ch_sreq_ready = hs ? NUM_CHANNEL'(1) << sreq_chid : '0;
  assign burden = |ydata[BW_LPI_YDATA-1 -: BW_LPI_BURDEN];
  assign yready = live & !empty & (!burden | ch_yready[head]);
  assign ch_yvalid = live & yvalid & !empty & burden ? NUM_CHANNEL'(1) << head : '0;
  assign ch_ydata = ydata;
  assign pop = yvalid & yready;
  assign busy = count != '0;
  assign outstanding = count;
  assign err_unexpected = err_q;
  always_comb begin
    gnt_valid_d = sreq_valid & !sreq_ready;
    gnt_d = sreq_chid;
    rr_d = clear ? '0 : !hs ? rr_q : sreq_chid == BW_CHID'(NUM_CHANNEL - 1) ? '0 : sreq_chid + 1'b1;
    err_d = clear ? 1'b0 : err_q | (yvalid & empty);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_valid_q <= 1'b0;
      gnt_q <= '0;
      rr_q <= '0;
      err_q <= 1'b0;
    end else begin
      gnt_valid_q <= gnt_valid_d;
      gnt_q <= gnt_d;
      rr_q <= rr_d;
      err_q <= err_d;
    end
  end
  dca_lpi_tag_fifo #(.W(BW_CHID), .DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(clear),
    .push(hs),
    .din(sreq_chid),
    .pop(pop),
    .full(full),
    .empty(empty),
    .count(count),
    .head(head)
  );
endmodule

// File: tb/tb_dca_lpi_outstanding_tracker.sv
// tb_dca_lpi_outstanding_tracker: scoreboard bench for the LPI outstanding tracker
module tb_dca_lpi_outstanding_tracker;
  logic clk = 0, rst = 1, clear = 0, enable = 0, sreq_ready = 0, yvalid = 0;
  logic [1:0] ch_sreq_valid = '0, ch_yready = '0, ch_sreq_ready, ch_yvalid;
  logic sreq_valid, sreq_chid, yready, busy, err_unexpected;
  logic [31:0] ydata = 32'hABCD_0123, ch_ydata;
  logic [2:0] outstanding;
  int compared = 0, mismatched = 0;
  int exp_q[$];
  always #5 clk = ~clk;
  dca_lpi_outstanding_tracker dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .enable(enable),
    .ch_sreq_valid(ch_sreq_valid),
    .ch_sreq_ready(ch_sreq_ready),
    .sreq_valid(sreq_valid),
    .sreq_ready(sreq_ready),
    .sreq_chid(sreq_chid),
    .yvalid(yvalid),
    .yready(yready),
    .ydata(ydata),
    .ch_yvalid(ch_yvalid),
    .ch_yready(ch_yready),
    .ch_ydata(ch_ydata),
    .busy(busy),
    .outstanding(outstanding),
    .err_unexpected(err_unexpected)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst && yvalid && yready && ch_yvalid != 0) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(ch_yvalid), 0);
      else begin
        check("route", 32'(ch_yvalid), 32'(1) << exp_q.pop_front());
        check("ydata", ch_ydata, ydata);
      end
    end
  end
  initial begin
    enable = 1;
    ch_sreq_valid = 2'b01;
    yvalid = 1;
    tick;
    tick;
    check("rst_cnt", 32'(outstanding), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_unexpected), 0);
    check("rst_sv", 32'(sreq_valid), 0);
    check("rst_csr", 32'(ch_sreq_ready), 0);
    check("rst_yr", 32'(yready), 0);
    check("rst_cyv", 32'(ch_yvalid), 0);
    check("rst_ydata", ch_ydata, 32'hABCD_0123);
    yvalid = 0;
    ch_sreq_valid = 0;
    rst = 0;
    tick;
    ch_sreq_valid = 2'b01;
    sreq_ready = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", 32'(sreq_valid), 1);
      check("t1_chid", 32'(sreq_chid), 0);
      check("t1_ready", 32'(ch_sreq_ready), 1);
      exp_q.push_back(0);
      tick;
      check("t1_cnt", 32'(outstanding), i + 1);
    end
    check("t1_full_block", 32'(sreq_valid), 0);
    check("t1_busy", 32'(busy), 1);
    ch_sreq_valid = 0;
    yvalid = 1;
    ch_yready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      ydata = 32'h8000_0000 | i;
      #1;
      check("t1_yready", 32'(yready), 1);
      tick;
      check("t1_drain", 32'(outstanding), 3 - i);
    end
    yvalid = 0;
    check("t1_idle", 32'(busy), 0);
    clear = 1;
    tick;
    clear = 0;
    ch_sreq_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t2_chid", 32'(sreq_chid), i % 2);
      check("t2_ready", 32'(ch_sreq_ready), i % 2 ? 2 : 1);
      exp_q.push_back(i % 2);
      tick;
    end
    ch_sreq_valid = 0;
    check("t2_cnt", 32'(outstanding), 4);
    yvalid = 1;
    for (int i = 0; i < 4; i++) begin
      ydata = 32'h8000_0100 + i;
      tick;
    end
    yvalid = 0;
    check("t2_drain", 32'(outstanding), 0);
    ch_sreq_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(0);
      tick;
    end
    check("t3_full", 32'(outstanding), 4);
    yvalid = 1;
    ydata = 32'h8000_0055;
    #1;
    check("t3_blocked", 32'(sreq_valid), 0);
    check("t3_yready", 32'(yready), 1);
    tick;
    check("t3_pop_only", 32'(outstanding), 3);
    yvalid = 0;
    #1;
    check("t3_valid", 32'(sreq_valid), 1);
    exp_q.push_back(0);
    tick;
    check("t3_refill", 32'(outstanding), 4);
    ch_sreq_valid = 0;
    ch_yready = 0;
    yvalid = 1;
    ydata = 32'h0000_1234;
    #1;
    check("t4_discard_rdy", 32'(yready), 1);
    check("t4_discard_nov", 32'(ch_yvalid), 0);
    tick;
    exp_q.delete(0);
    check("t4_discard_pop", 32'(outstanding), 3);
    ydata = 32'h8000_1234;
    #1;
    check("t4_stall_rdy", 32'(yready), 0);
    check("t4_stall_v", 32'(ch_yvalid), 1);
    tick;
    tick;
    check("t4_stall_hold", 32'(outstanding), 3);
    ch_yready = 2'b01;
    for (int i = 0; i < 3; i++) tick;
    yvalid = 0;
    check("t4_drain", 32'(outstanding), 0);
    check("t4_sb_empty", exp_q.size(), 0);
    yvalid = 1;
    ydata = 32'h8000_0000;
    #1;
    check("t5_yready", 32'(yready), 0);
    check("t5_err_pre", 32'(err_unexpected), 0);
    tick;
    check("t5_err_set", 32'(err_unexpected), 1);
    yvalid = 0;
    tick;
    check("t5_err_sticky", 32'(err_unexpected), 1);
    clear = 1;
    tick;
    clear = 0;
    #1;
    check("t5_err_clr", 32'(err_unexpected), 0);
    check("t5_cnt", 32'(outstanding), 0);
    sreq_ready = 0;
    ch_sreq_valid = 2'b10;
    #1;
    check("t6_valid", 32'(sreq_valid), 1);
    check("t6_chid", 32'(sreq_chid), 1);
    tick;
    enable = 0;
    ch_sreq_valid = 2'b01;
    #1;
    check("t6_hold_v", 32'(sreq_valid), 1);
    check("t6_hold_id", 32'(sreq_chid), 1);
    tick;
    check("t6_hold_id2", 32'(sreq_chid), 1);
    sreq_ready = 1;
    #1;
    check("t6_hs", 32'(ch_sreq_ready), 2);
    exp_q.push_back(1);
    tick;
    check("t6_cnt1", 32'(outstanding), 1);
    enable = 1;
    ch_sreq_valid = 2'b10;
    #1;
    check("t6_chid_b", 32'(sreq_chid), 1);
    exp_q.push_back(1);
    tick;
    ch_sreq_valid = 2'b01;
    #1;
    check("t6_chid_c", 32'(sreq_chid), 0);
    exp_q.push_back(0);
    tick;
    ch_sreq_valid = 0;
    check("t6_cnt3", 32'(outstanding), 3);
    clear = 1;
    tick;
    clear = 0;
    exp_q.delete();
    #1;
    check("t6_clr_cnt", 32'(outstanding), 0);
    check("t6_clr_busy", 32'(busy), 0);
    sreq_ready = 0;
    ch_sreq_valid = 2'b11;
    #1;
    check("t6_rr_reset", 32'(sreq_chid), 0);
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
